// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types and constants for the paddle pulse decoder
package paddle_pkg;

    localparam int POS_W             = 8;
    localparam int MAX_COUNT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/paddle_chan_decoder.sv
// rtl/paddle_chan_decoder.sv - one channel: line counter, state machine and position latch
module paddle_chan_decoder
    import paddle_pkg::*;
#(
    parameter bit INVERT    = 1'b0,
    parameter int MAX_COUNT = MAX_COUNT_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             vs_edge,
    input  logic             hs_edge,
    input  logic             pad,
    output logic [POS_W-1:0] pos,
    output logic             pos_stb,
    output logic             timeout
);

    localparam logic [POS_W-1:0] MAX_C    = POS_W'(MAX_COUNT);
    localparam logic [POS_W-1:0] INV_MASK = {POS_W{INVERT}};

    chan_state_t      state, state_next;
    logic [POS_W-1:0] cnt, cnt_next;
    logic [POS_W-1:0] pos_next;
    logic             stb_next;
    logic             timeout_next;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pos     <= '0;
            pos_stb <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pos     <= pos_next;
            pos_stb <= stb_next;
            timeout <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pos_next     = pos;
        stb_next     = 1'b0;
        timeout_next = timeout;

        if (vs_edge) begin
            // A frame that ends still armed never saw the paddle: report full scale.
            if (state == ARMED) begin
                pos_next     = MAX_C ^ INV_MASK;
                stb_next     = 1'b1;
                timeout_next = 1'b1;
            end
            cnt_next   = '0;
            state_next = ARMED;
        end else if (state == ARMED) begin
            if (pad) begin
                pos_next     = cnt ^ INV_MASK;
                stb_next     = 1'b1;
                timeout_next = 1'b0;
                state_next   = DONE;
            end else if (hs_edge && (cnt < MAX_C)) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_pulse_decoder.sv
// rtl/paddle_pulse_decoder.sv - two-channel paddle position decoder with shared sync edge detect
module paddle_pulse_decoder
    import paddle_pkg::*;
#(
    parameter bit INVERT0   = 1'b0,
    parameter bit INVERT1   = 1'b0,
    parameter int MAX_COUNT = MAX_COUNT_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hs,
    input  logic             vs,
    input  logic [1:0]       pad_in,
    output logic [POS_W-1:0] pos0,
    output logic [POS_W-1:0] pos1,
    output logic [1:0]       pos_stb,
    output logic [1:0]       timeout
);

    logic       hs_q;
    logic       vs_q;
    logic [1:0] pad_q;
    logic       sync_valid;
    logic       hs_edge;
    logic       vs_edge;

    // sync_valid masks the first cycle after reset so a level already high
    // at release loads the history register instead of looking like an edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            pad_q      <= 2'b00;
            sync_valid <= 1'b0;
        end else begin
            hs_q       <= hs;
            vs_q       <= vs;
            pad_q      <= pad_in;
            sync_valid <= 1'b1;
        end
    end

    assign hs_edge = sync_valid & hs & ~hs_q;
    assign vs_edge = sync_valid & vs & ~vs_q;

    paddle_chan_decoder #(
        .INVERT    (INVERT0),
        .MAX_COUNT (MAX_COUNT)
    ) u_chan0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .vs_edge (vs_edge),
        .hs_edge (hs_edge),
        .pad     (pad_q[0]),
        .pos     (pos0),
        .pos_stb (pos_stb[0]),
        .timeout (timeout[0])
    );

    paddle_chan_decoder #(
        .INVERT    (INVERT1),
        .MAX_COUNT (MAX_COUNT)
    ) u_chan1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .vs_edge (vs_edge),
        .hs_edge (hs_edge),
        .pad     (pad_q[1]),
        .pos     (pos1),
        .pos_stb (pos_stb[1]),
        .timeout (timeout[1])
    );

endmodule

// File: tb/tb_paddle_pulse_decoder.sv
// tb/tb_paddle_pulse_decoder.sv - directed self-checking bench for paddle_pulse_decoder
module tb_paddle_pulse_decoder;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       hs;
    logic       vs;
    logic [1:0] pad_in;
    logic [7:0] pos0, pos1, pos0_i, pos1_i;
    logic [1:0] pos_stb, pos_stb_i, timeout, timeout_i;

    int checks   = 0;
    int failures = 0;
    int stb_cnt0 = 0;
    int stb_cnt1 = 0;
    int snap0, snap1;

    always #5 clk_sys = ~clk_sys;

    paddle_pulse_decoder dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .hs      (hs),
        .vs      (vs),
        .pad_in  (pad_in),
        .pos0    (pos0),
        .pos1    (pos1),
        .pos_stb (pos_stb),
        .timeout (timeout)
    );

    paddle_pulse_decoder #(.INVERT0(1'b1)) dut_inv (
        .clk_sys (clk_sys),
        .reset   (reset),
        .hs      (hs),
        .vs      (vs),
        .pad_in  (pad_in),
        .pos0    (pos0_i),
        .pos1    (pos1_i),
        .pos_stb (pos_stb_i),
        .timeout (timeout_i)
    );

    always @(negedge clk_sys) begin
        if (pos_stb[0]) stb_cnt0 <= stb_cnt0 + 1;
        if (pos_stb[1]) stb_cnt1 <= stb_cnt1 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic vs_rise();
        vs = 1'b1;
        tick(1);
    endtask

    task automatic vs_fall();
        vs = 1'b0;
        tick(1);
    endtask

    task automatic hs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            hs = 1'b1;
            tick(1);
            hs = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        reset  = 1'b1;
        hs     = 1'b0;
        vs     = 1'b0;
        pad_in = 2'b00;
        tick(3);
        check_eq("rst_pos0", pos0, 8'h00);
        check_eq("rst_pos1", pos1, 8'h00);
        check_eq("rst_stb", pos_stb, 2'b00);
        check_eq("rst_timeout", timeout, 2'b00);
        check_eq("rst_pos0_inv", pos0_i, 8'h00);

        // vs already high at release is not an edge; channels stay idle
        vs = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        pad_in = 2'b11;
        tick(3);
        pad_in = 2'b00;
        tick(3);
        check_eq("rel_vs_high_stb0", stb_cnt0, 0);
        check_eq("rel_vs_high_stb1", stb_cnt1, 0);
        check_eq("rel_vs_high_pos0", pos0, 8'h00);
        vs_fall();

        // frame: 37 lines then channel 0 paddle, 2-cycle latency
        vs_rise();
        check_eq("f1_vs_stb", pos_stb, 2'b00);
        vs_fall();
        hs_pulses(37);
        pad_in = 2'b01;
        tick(1);
        check_eq("f1_lat1_stb", pos_stb, 2'b00);
        tick(1);
        check_eq("f1_pos0", pos0, 8'd37);
        check_eq("f1_stb", pos_stb, 2'b01);
        check_eq("f1_timeout", timeout, 2'b00);
        check_eq("f1_pos0_inv", pos0_i, 8'hDA);
        tick(1);
        check_eq("f1_stb_once", pos_stb, 2'b00);
        pad_in = 2'b00;

        // channel 1 still armed: frame end times it out
        vs_rise();
        check_eq("f2_to_pos1", pos1, 8'hFF);
        check_eq("f2_to_stb", pos_stb, 2'b10);
        check_eq("f2_to_timeout", timeout, 2'b10);
        check_eq("f2_pos0_hold", pos0, 8'd37);
        vs_fall();
        hs_pulses(3);
        pad_in = 2'b10;
        tick(2);
        check_eq("f2_pos1", pos1, 8'd3);
        check_eq("f2_stb1", pos_stb, 2'b10);
        check_eq("f2_timeout_clr", timeout, 2'b00);
        hs_pulses(2);
        // hs edge seen by the decoder together with registered pad: pre-increment value
        pad_in = 2'b11;
        tick(1);
        hs = 1'b1;
        tick(1);
        check_eq("f2_coinc_pos0", pos0, 8'd5);
        check_eq("f2_coinc_stb", pos_stb, 2'b01);
        hs = 1'b0;
        tick(1);

        // pad_in[1] held high across the vs edge latches 0
        pad_in = 2'b10;
        vs_rise();
        check_eq("f3_vs_stb", pos_stb, 2'b00);
        tick(1);
        check_eq("f3_pos1_zero", pos1, 8'd0);
        check_eq("f3_stb1", pos_stb, 2'b10);
        vs_fall();
        check_eq("f3_stb_once", pos_stb, 2'b00);
        pad_in = 2'b00;

        vs_rise();
        check_eq("f4_to_pos0", pos0, 8'hFF);
        check_eq("f4_to_stb", pos_stb, 2'b01);
        check_eq("f4_to_timeout", timeout, 2'b01);
        vs_fall();
        hs_pulses(300);
        vs_rise();
        check_eq("f5_pos0", pos0, 8'hFF);
        check_eq("f5_pos1", pos1, 8'hFF);
        check_eq("f5_stb", pos_stb, 2'b11);
        check_eq("f5_timeout", timeout, 2'b11);
        check_eq("f5_pos0_inv", pos0_i, 8'h00);
        check_eq("f5_pos1_inv", pos1_i, 8'hFF);
        check_eq("f5_stb_inv", pos_stb_i, 2'b11);
        check_eq("f5_timeout_inv", timeout_i, 2'b11);
        vs_fall();
        hs_pulses(10);
        pad_in = 2'b01;
        tick(2);
        check_eq("f6_pos0", pos0, 8'd10);
        check_eq("f6_stb", pos_stb, 2'b01);
        check_eq("f6_timeout", timeout, 2'b10);
        check_eq("f6_pos0_inv", pos0_i, 8'hF5);
        pad_in = 2'b00;
        hs_pulses(290);
        pad_in = 2'b10;
        tick(2);
        check_eq("f6_sat_pos1", pos1, 8'hFF);
        check_eq("f6_sat_stb", pos_stb, 2'b10);
        check_eq("f6_sat_timeout", timeout, 2'b00);
        pad_in = 2'b00;

        // reset at line 50 of an armed frame
        vs_rise();
        check_eq("f7_vs_stb", pos_stb, 2'b00);
        vs_fall();
        hs_pulses(50);
        snap0 = stb_cnt0;
        snap1 = stb_cnt1;
        reset = 1'b1;
        tick(2);
        check_eq("f7_rst_pos0", pos0, 8'h00);
        check_eq("f7_rst_pos1", pos1, 8'h00);
        check_eq("f7_rst_pos0_inv", pos0_i, 8'h00);
        check_eq("f7_rst_stb", pos_stb, 2'b00);
        reset = 1'b0;
        tick(2);
        pad_in = 2'b11;
        tick(3);
        pad_in = 2'b00;
        tick(3);
        vs_rise();
        check_eq("f7_idle_vs_stb", pos_stb, 2'b00);
        vs_fall();
        check_eq("f7_nostb0", stb_cnt0 - snap0, 0);
        check_eq("f7_nostb1", stb_cnt1 - snap1, 0);
        check_eq("f7_idle_pos0", pos0, 8'h00);
        hs_pulses(20);
        pad_in = 2'b01;
        tick(2);
        check_eq("f8_pos0", pos0, 8'd20);
        check_eq("f8_stb", pos_stb, 2'b01);
        check_eq("f8_pos0_inv", pos0_i, 8'hEB);
        pad_in = 2'b00;
        tick(2);
        check_eq("total_stb0", stb_cnt0, 6);
        check_eq("total_stb1", stb_cnt1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
